// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_ctrl_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 : shown on if_instr whenever the IF/ID slot is empty
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_skid_buf.sv
// rtl/fetch_ctrl_skid_buf.sv - one-entry {pc,instr} skid buffer for fetch responses
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   load               capture load_pc/load_instr, mark valid
//   pop                entry consumed, mark empty
//   clear              flush entry (dominates load and pop)
//   load_pc/load_instr data to capture
//   valid/pc/instr     held entry
module fetch_ctrl_skid_buf
    import fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            pop,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = load_pc;
            instr_d = load_instr;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: PC register, imem handshake, IF/ID slot
//
// Optional build macro FETCH_PERF_EN adds perf_fetch_cnt / perf_flush_cnt outputs.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   redirect, redirect_pc          flush and new fetch PC from next-PC selector
//   stall                          hazard unit holds the IF/ID slot
//   imem_req/imem_addr/imem_gnt    request handshake (one outstanding at most)
//   imem_rvalid/imem_rdata         response
//   if_valid/if_pc/if_instr/if_pc4 IF/ID slot towards decode
//   busy                           request outstanding (WAIT or DRAIN)
//   perf_fetch_cnt/perf_flush_cnt  (FETCH_PERF_EN only) event counters
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    output logic        busy
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;

    logic         skid_valid, skid_load, skid_pop, skid_clear;
    logic [31:0]  skid_pc, skid_instr;
    logic         flush, gnt_fire, resp_live, resp_to_slot;

    // No new request while the skid holds an entry: that is what keeps
    // a second response from ever arriving with the skid full.
    assign imem_req  = (state_q == ST_REQ) && !skid_valid;
    assign imem_addr = pc_q;
    assign busy      = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    assign gnt_fire  = imem_req && imem_gnt;
    assign flush     = redirect && (state_q != ST_BOOT);
    assign resp_live = (state_q == ST_WAIT) && imem_rvalid && !flush;
    assign resp_to_slot = resp_live && (!if_valid_q || !stall);
    assign skid_load    = resp_live && if_valid_q && stall;
    assign skid_clear   = flush;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        skid_pop   = 1'b0;

        case (state_q)
            ST_BOOT:  state_d = ST_REQ;
            ST_REQ: begin
                if (gnt_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT:  if (imem_rvalid) state_d = ST_REQ;
            ST_DRAIN: if (imem_rvalid) state_d = ST_REQ;
            default:  state_d = ST_BOOT;
        endcase

        if (flush) begin
            pc_d = {redirect_pc[31:2], 2'b00};
            // A request granted this cycle, or still unanswered in WAIT,
            // carries a stale address; its response must be dropped.
            // In DRAIN a response arriving now is exactly the pending discard.
            if ((state_q == ST_REQ && gnt_fire) || (state_q == ST_WAIT && !imem_rvalid))
                state_d = ST_DRAIN;
            else if (state_q == ST_DRAIN && !imem_rvalid)
                state_d = ST_DRAIN;
            else
                state_d = ST_REQ;
        end

        if (flush) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end else if (!stall && skid_valid) begin
            if_valid_d = 1'b1;
            if_pc_d    = skid_pc;
            if_instr_d = skid_instr;
            skid_pop   = 1'b1;
        end else if (resp_to_slot) begin
            if_valid_d = 1'b1;
            if_pc_d    = req_pc_q;
            if_instr_d = imem_rdata;
        end else if (!stall) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    fetch_ctrl_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .pop        (skid_pop),
        .clear      (skid_clear),
        .load_pc    (req_pc_q),
        .load_instr (imem_rdata),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;
    assign if_pc4   = if_pc_q + 32'd4;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q + {31'd0, resp_live};
        perf_flush_cnt_d = perf_flush_cnt_q + {31'd0, flush};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`endif

    skid_never_overrun: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && skid_valid));

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 5-stage RISC-V pipeline. Owns the architectural PC register and drives the instruction-memory request/response handshake.
- Presents fetched instructions to the IF/ID boundary.
- Applies redirect/flush requests from the next-PC selector and stall requests from the hazard unit.
- At most one imem request outstanding; one-entry skid buffer absorbs a response that arrives under stall.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
- NOP_INSTR, 32'h0000_0013, value driven on if_instr when the slot is empty or after reset (addi x0,x0,0).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- redirect  in  1  flush from next-PC selector; redirect_pc becomes fetch PC
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
- stall  in  1  hazard unit: IF/ID must hold current slot
- imem_req  out  1  request valid
- imem_addr  out  32  request address, word aligned
- imem_gnt  in  1  request accepted this cycle (imem_req & imem_gnt)
- imem_rvalid  in  1  response valid; exactly one per granted request, ≥1 cycle after grant
- imem_rdata  in  32  response instruction
- if_valid  out  1  IF/ID slot holds a live instruction
- if_pc  out  32  PC of slot instruction
- if_instr  out  32  slot instruction
- if_pc4  out  32  if_pc + 4, feeds next-PC selector
- busy  out  1  request outstanding (state WAIT or DRAIN)

Behaviour:
- Reset: pc=RESET_PC, state=BOOT, imem_req=0, if_valid=0, if_pc=0, if_instr=NOP_INSTR, skid empty, busy=0.
- FSM states: BOOT, REQ, WAIT, DRAIN.
- BOOT: no request; always → REQ next cycle.
- REQ:
  - imem_req = !skid_valid; imem_addr = pc.
  - imem_addr only changes while req is pending if redirect occurs.
  - Handshake on imem_req & imem_gnt: req_pc <= pc, pc <= pc+4 (mod 2^32), → WAIT.
- WAIT: busy=1, imem_req=0. On imem_rvalid, the response goes to:
  - slot, if !if_valid | !stall: slot <= {req_pc, rdata}, if_valid=1.
  - skid, otherwise.
  - Then → REQ.
- DRAIN: busy=1. Next imem_rvalid is discarded, → REQ.
- Redirect (highest priority, any state except BOOT):
  - pc <= {redirect_pc[31:2],2'b00}; if_valid <= 0; skid cleared.
  - REQ without gnt: stay REQ; new address presented next cycle.
  - REQ with gnt same cycle: accepted request is stale; → DRAIN.
  - WAIT without rvalid: → DRAIN.
  - WAIT with rvalid same cycle: data discarded, → REQ.
  - DRAIN: stay DRAIN (pc updated; one discard still pending).
- Slot consumption: each cycle stall=0, downstream takes the slot.
  - If skid_valid: slot <= skid, skid cleared.
  - Else if no response loaded that cycle: if_valid <= 0, if_instr <= NOP_INSTR.
- Stall with if_valid=1: if_valid/if_pc/if_instr held bit-stable.
- Simultaneous rvalid + skid full is impossible (no request issued while skid full); treat as assertion failure.
- Redirect dominates stall.
- if_pc4 = if_pc + 4, combinational, wraps at 2^32.
- Throughput with gnt same-cycle and rvalid next cycle: one instruction per 2 cycles.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_flush_cnt[31:0], both reset to 0 and wrapping.
  - perf_fetch_cnt increments on each response loaded into slot or skid.
  - perf_flush_cnt increments on each cycle redirect=1 in a state other than BOOT.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package:
  - FSM state typedef (BOOT/REQ/WAIT/DRAIN, 2-bit).
  - NOP_INSTR constant.
  - XLEN=32.
- One natural sub-module: fetch_skid_buf, a one-entry {pc,instr} buffer with load/pop/clear and valid flag.

Test Plan:
- Reset then gnt=1 every REQ, rvalid 1 cycle after gnt, rdata=addr^32'hA5A5_0000 → imem_addr sequence 0,4,8,…; if_pc matches; if_valid pulses every 2nd cycle.
- Stall held 6 cycles while if_pc=0x8 valid, response for 0xC arrives → slot holds 0x8 stable; skid takes 0xC; imem_req=0; after stall drops, slot=0xC next cycle, then fetch 0x10.
- Redirect to 0x94 in WAIT, rvalid 2 cycles later → state DRAIN, response discarded, if_valid=0, next imem_addr=0x94.
- Redirect to 0x200 same cycle as gnt for 0x40 → 0x40 response discarded; next request 0x200.
- Redirect with redirect_pc=0x103 while stall=1 and skid full → if_valid=0, skid cleared, next imem_addr=0x100.
- rst asserted in WAIT with rvalid pending → outputs return to reset values; late rvalid ignored; first request after BOOT is RESET_PC.
